// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the R3 instruction fetch front end.
//   fetch_state_t        - fetch sequencer states (BOOT, RUN, FAULT)
//   FETCH_FIFO_DEPTH     - depth of the fetched-instruction buffer
//   DEFAULT_RESET_VECTOR - first fetch address used when the top is not overridden
//   fetch_entry_t        - one buffered instruction word with its PC (32-bit core)
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int FETCH_FIFO_DEPTH = 2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO holding fetched instructions and their PCs.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   i_push        - write i_push_data (ignored when full and not popping)
//   i_push_data   - entry to write
//   i_pop         - drop the head entry (ignored when empty)
//   i_flush       - discard all entries; wins over push/pop in the same cycle
//   o_count       - number of valid entries (0..2)
//   o_head        - oldest entry; contents are stale when o_count is 0
// ENTRY_T defaults to the 32-bit fetch_entry_t; the top passes a width-matched type.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type ENTRY_T = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  ENTRY_T     i_push_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output logic [1:0] o_count,
  output ENTRY_T     o_head
);

  ENTRY_T     r_mem [FETCH_FIFO_DEPTH];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != 2'(FETCH_FIFO_DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end of the R3 single-issue core.
// Holds the fetch PC, issues word reads over a req/ready + rvalid handshake,
// buffers returned words with their PCs and presents one per cycle downstream.
// A taken redirect (PCsrc in a consume cycle) retargets fetch to instr_pc + ImmOp
// and discards wrong-path responses still in flight.
//
// Configuration macro: FETCH_MISALIGN_CHECK_EN
//   defined   - a redirect to a target with [1:0] != 0 enters the terminal FAULT
//               state and raises the sticky fetch_fault flag
//   undefined - target bits [1:0] are forced to 00 and fetch_fault is tied 0
//
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   imem_req / imem_addr     - fetch request and word-aligned address
//   imem_ready               - memory accepts the request this cycle
//   imem_rvalid / imem_rdata - in-order response
//   instr / instr_pc         - head instruction and its PC
//   instr_valid              - head is valid
//   dec_ready                - downstream consumes the head this cycle
//   PCsrc / ImmOp            - redirect request and sign-extended offset
//   fetch_fault              - sticky misaligned-target flag
//
// state | meaning
// BOOT  | first cycle after reset release, no request
// RUN   | normal fetch
// FAULT | misaligned redirect seen, terminal until reset
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  input  logic                     dec_ready,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  output logic                     fetch_fault
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0] r_rsp_pc;
  logic [1:0]               r_outstanding;
  logic [1:0]               r_discard;

  logic [1:0]               w_fifo_count;
  entry_t                   w_head;
  entry_t                   w_push_data;
  logic                     w_consume;
  logic                     w_redirect;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_drop_rsp;
  logic [2:0]               w_credit_used;
  logic [1:0]               w_outstanding_nxt;
  logic [ADDRESS_WIDTH-1:0] w_target_raw;
  logic [ADDRESS_WIDTH-1:0] w_target;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                     w_misalign;
`endif

  assign instr_valid = (r_state == RUN) && (w_fifo_count != 2'd0);
  assign w_consume   = instr_valid && dec_ready;
  assign w_redirect  = w_consume && PCsrc;

  assign w_target_raw = w_head.pc + ImmOp;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_target   = w_target_raw;
  assign w_misalign = (w_target_raw[1:0] != 2'b00);
`else
  assign w_target   = w_target_raw & ~ADDRESS_WIDTH'(3);
`endif

  // Credit counts the head leaving this cycle so 1-cycle memory sustains one
  // instruction per cycle. Without an accept the sum never grows, so a raised
  // request stays raised until accepted.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count} - {2'b00, w_consume};

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        imem_req = (w_credit_used < 3'd2);
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_redirect && w_misalign) begin
          w_state_nxt = FAULT;
        end
`endif
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_accept          = imem_req && imem_ready;
  assign w_outstanding_nxt = r_outstanding + {1'b0, w_accept} - {1'b0, imem_rvalid};
  assign w_drop_rsp        = imem_rvalid && (r_discard != 2'd0);
  // Responses are dropped while wrong-path words drain, in the redirect cycle
  // itself, and in any state other than RUN.
  assign w_push            = imem_rvalid && (r_discard == 2'd0) && !w_redirect
                             && (r_state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_rsp_pc      <= RESET_VECTOR;
      r_outstanding <= 2'd0;
      r_discard     <= 2'd0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (w_redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        r_discard  <= w_outstanding_nxt;
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
      end else begin
        if (w_drop_rsp) begin
          r_discard <= r_discard - 2'd1;
        end
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + ADDRESS_WIDTH'(4);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + ADDRESS_WIDTH'(4);
        end
      end
    end
  end

  assign w_push_data.instr = imem_rdata;
  assign w_push_data.pc    = r_rsp_pc;

  fetch_fifo #(
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_consume),
    .i_flush     (w_redirect),
    .o_count     (w_fifo_count),
    .o_head      (w_head)
  );

  assign imem_addr = r_fetch_pc;
  assign instr     = w_head.instr;
  assign instr_pc  = w_head.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = (r_state == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a queue-based memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready = 1'b1;
  logic        PCsrc = 1'b0;
  logic [31:0] ImmOp = 32'h0;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  logic        mem_hold = 1'b0;
  logic        acc = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] mem_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Capture the request that the next rising edge will accept.
  initial begin
    forever begin
      @(negedge clk);
      acc      = rst_n && imem_req && imem_ready;
      acc_addr = imem_addr;
    end
  end

  // Responses come back in order, the cycle after acceptance unless held.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_q.delete();
        imem_rvalid = 1'b0;
      end else begin
        if (acc) mem_q.push_back(acc_addr);
        if (!mem_hold && mem_q.size() > 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_q.pop_front());
        end else begin
          imem_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    PCsrc     = 1'b0;
    ImmOp     = 32'h0;
    dec_ready = 1'b1;
    imem_ready = 1'b1;
    mem_hold  = 1'b0;
    tick();
    tick();
  endtask

  task automatic redirect(input logic [31:0] imm);
    PCsrc = 1'b1;
    ImmOp = imm;
    tick();
    PCsrc = 1'b0;
    ImmOp = 32'h0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !instr_valid; i++) tick();
    chk(tag, {31'h0, instr_valid}, 32'h1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    for (int i = 0; i < budget && !imem_req; i++) tick();
    chk(tag, {31'h0, imem_req}, 32'h1);
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] pc, input int budget);
    for (int i = 0; i < budget && !(instr_valid && instr_pc == pc); i++) tick();
    chk(tag, instr_pc, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, first requests and first-instruction latency.
    do_reset();
    chk("rst_req",   {31'h0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc",    instr_pc, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("boot_req",  {31'h0, imem_req}, 32'h1);
    chk("boot_addr", imem_addr, 32'h0);
    tick();
    chk("a4_addr",   imem_addr, 32'h4);
    chk("a4_valid",  {31'h0, instr_valid}, 32'h0);
    tick();
    chk("first_valid", {31'h0, instr_valid}, 32'h1);
    chk("first_pc",    instr_pc, 32'h0);
    chk("first_instr", instr, mem_word(32'h0));
    chk("a8_addr",     imem_addr, 32'h8);
    chk("a8_req",      {31'h0, imem_req}, 32'h1);

    // Backpressure: FIFO fills, request drops, order preserved.
    do_reset();
    dec_ready = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("bp_req",   {31'h0, imem_req}, 32'h0);
    chk("bp_valid", {31'h0, instr_valid}, 32'h1);
    chk("bp_pc0",   instr_pc, 32'h0);
    chk("bp_i0",    instr, mem_word(32'h0));
    dec_ready = 1'b1;
    #1;
    chk("bp_req_resume", {31'h0, imem_req}, 32'h1);
    chk("bp_addr8",      imem_addr, 32'h8);
    tick();
    chk("bp_pc4", instr_pc, 32'h4);
    chk("bp_i4",  instr, mem_word(32'h4));
    tick();
    chk("bp_pc8", instr_pc, 32'h8);
    chk("bp_i8",  instr, mem_word(32'h8));

    // Redirect at 0x8 by +0x20 with two requests in flight.
    do_reset();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rd_pc4", instr_pc, 32'h4);
    mem_hold = 1'b1;
    tick();
    chk("rd_pc8", instr_pc, 32'h8);
    redirect(32'h20);
    chk("rd_addr",  imem_addr, 32'h28);
    chk("rd_req",   {31'h0, imem_req}, 32'h0);
    chk("rd_valid", {31'h0, instr_valid}, 32'h0);
    mem_hold = 1'b0;
    wait_req("rd_req_wait", 20);
    chk("rd_addr_req", imem_addr, 32'h28);
    wait_valid("rd_valid_wait", 20);
    chk("rd_pc28", instr_pc, 32'h28);
    chk("rd_i28",  instr, mem_word(32'h28));

    // Negative offset, then wrap of the fetch PC past the top.
    do_reset();
    rst_n = 1'b1;
    wait_pc("neg_find10", 32'h10, 30);
    redirect(32'hFFFF_FFF8);
    chk("neg_addr", imem_addr, 32'h8);
    wait_valid("neg_valid", 20);
    chk("neg_pc8", instr_pc, 32'h8);
    redirect(32'hFFFF_FFF4);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_valid1", 20);
    chk("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_i_top",  instr, mem_word(32'hFFFF_FFFC));
    tick();
    wait_valid("wrap_valid2", 20);
    chk("wrap_pc0", instr_pc, 32'h0);
    chk("wrap_i0",  instr, mem_word(32'h0));

    // Misaligned target.
    do_reset();
    rst_n = 1'b1;
    wait_valid("mis_valid0", 20);
    chk("mis_pc0", instr_pc, 32'h0);
    redirect(32'h6);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
    chk("mis_req",   {31'h0, imem_req}, 32'h0);
    chk("mis_valid", {31'h0, instr_valid}, 32'h0);
    repeat (6) tick();
    chk("mis_fault_hold", {31'h0, fetch_fault}, 32'h1);
    chk("mis_req_hold",   {31'h0, imem_req}, 32'h0);
    chk("mis_valid_hold", {31'h0, instr_valid}, 32'h0);
`else
    chk("mis_fault", {31'h0, fetch_fault}, 32'h0);
    chk("mis_addr",  imem_addr, 32'h4);
    wait_valid("mis_valid4", 20);
    chk("mis_pc4", instr_pc, 32'h4);
    chk("mis_i4",  instr, mem_word(32'h4));
`endif

    // Reset asserted with two requests outstanding.
    do_reset();
    rst_n = 1'b1;
    wait_pc("mr_find8", 32'h8, 30);
    mem_hold = 1'b1;
    repeat (4) tick();
    chk("mr_req_stall",   {31'h0, imem_req}, 32'h0);
    chk("mr_valid_stall", {31'h0, instr_valid}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_req",   {31'h0, imem_req}, 32'h0);
    chk("mr_addr",  imem_addr, 32'h0);
    chk("mr_valid", {31'h0, instr_valid}, 32'h0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_pc",    instr_pc, 32'h0);
    chk("mr_fault", {31'h0, fetch_fault}, 32'h0);
    mem_hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_restart_req",  {31'h0, imem_req}, 32'h1);
    chk("mr_restart_addr", imem_addr, 32'h0);
    wait_valid("mr_valid_wait", 20);
    chk("mr_restart_pc", instr_pc, 32'h0);
    chk("mr_restart_i",  instr, mem_word(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
